// File: rtl/i2c_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : i2c_slave_if
// Brief   : I2C slave at a fixed 7-bit address backed by a 16-byte memory.
// Rev     : 1.0
// ============================================================================
module i2c_slave_if #(
   parameter int                        I2C_ADDR_WIDTH = 7,
   parameter int                        I2C_DATA_WIDTH = 8,
   parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS  = 7'h22
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      sda_oe,
   output logic                      busy,
   output logic                      xfer_valid,
   output logic                      xfer_rw,
   output logic [I2C_DATA_WIDTH-1:0] xfer_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
   } state_t;

   state_t                    state_q, state_d;
   logic [2:0]                scl_q, sda_q;
   logic [2:0]                cnt_q, cnt_d;
   logic [I2C_DATA_WIDTH-1:0] sr_q, sr_d;
   logic [3:0]                ptr_q, ptr_d;
   logic                      phase_q, phase_d;
   logic                      rw_q, rw_d;
   logic                      oe_q, oe_d;
   logic                      busy_q, busy_d;
   logic                      xv_q, xv_d;
   logic                      xrw_q, xrw_d;
   logic [I2C_DATA_WIDTH-1:0] xdata_q, xdata_d;
   logic [I2C_DATA_WIDTH-1:0] mem_q [16];
   logic                      w_mem_we;

   // Index 1 is the synchronized pin, index 2 its previous value.
   logic w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [I2C_DATA_WIDTH-1:0] w_shift_in;
   assign w_scl_rise = scl_q[1] & ~scl_q[2];
   assign w_scl_fall = ~scl_q[1] & scl_q[2];
   assign w_start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign w_stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
   assign w_shift_in = {sr_q[I2C_DATA_WIDTH-2:0], sda_q[1]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      ptr_d    = ptr_q;
      phase_d  = phase_q;
      rw_d     = rw_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      xv_d     = 1'b0;
      xrw_d    = xrw_q;
      xdata_d  = xdata_q;
      w_mem_we = 1'b0;
      if (w_start) begin
         state_d = S_ADDR;
         cnt_d   = '0;
         ptr_d   = '0;
         phase_d = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (w_stop) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: if (w_scl_rise) begin
               sr_d  = w_shift_in;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (w_shift_in[I2C_DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                     state_d = S_ADDR_ACK;
                     busy_d  = 1'b1;
                     rw_d    = w_shift_in[0];
                     phase_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            // First falling edge starts the ACK bit, second one ends it.
            S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
               if (!phase_q) begin
                  oe_d    = 1'b1;
                  phase_d = 1'b1;
               end else if (rw_q) begin
                  state_d = S_RD_DATA;
                  sr_d    = mem_q[ptr_q];
                  oe_d    = ~mem_q[ptr_q][I2C_DATA_WIDTH-1];
                  cnt_d   = '0;
               end else begin
                  state_d = S_WR_DATA;
                  oe_d    = 1'b0;
                  cnt_d   = '0;
               end
            end
            S_WR_DATA: if (w_scl_rise) begin
               sr_d  = w_shift_in;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  w_mem_we = 1'b1;
                  ptr_d    = ptr_q + 4'd1;
                  xv_d     = 1'b1;
                  xrw_d    = 1'b0;
                  xdata_d  = w_shift_in;
                  state_d  = S_WR_ACK;
                  phase_d  = 1'b0;
               end
            end
            // Rotating keeps the sent byte intact for the read strobe.
            S_RD_DATA: if (w_scl_fall) begin
               sr_d  = {sr_q[I2C_DATA_WIDTH-2:0], sr_q[I2C_DATA_WIDTH-1]};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  ptr_d   = ptr_q + 4'd1;
                  state_d = S_RD_ACK;
                  oe_d    = 1'b0;
                  phase_d = 1'b0;
               end else begin
                  oe_d = ~sr_q[I2C_DATA_WIDTH-2];
               end
            end
            S_RD_ACK: if (w_scl_rise) begin
               xv_d    = 1'b1;
               xrw_d   = 1'b1;
               xdata_d = sr_q;
               if (sda_q[1]) state_d = S_WAIT_STOP;
               else          phase_d = 1'b1;
            end else if (w_scl_fall && phase_q) begin
               state_d = S_RD_DATA;
               sr_d    = mem_q[ptr_q];
               oe_d    = ~mem_q[ptr_q][I2C_DATA_WIDTH-1];
               cnt_d   = '0;
            end
            S_IDLE, S_WAIT_STOP: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         scl_q   <= '1;
         sda_q   <= '1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         ptr_q   <= '0;
         phase_q <= 1'b0;
         rw_q    <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         xv_q    <= 1'b0;
         xrw_q   <= 1'b0;
         xdata_q <= '0;
         for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      end else begin
         scl_q   <= {scl_q[1:0], scl_i};
         sda_q   <= {sda_q[1:0], sda_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         ptr_q   <= ptr_d;
         phase_q <= phase_d;
         rw_q    <= rw_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         xv_q    <= xv_d;
         xrw_q   <= xrw_d;
         xdata_q <= xdata_d;
         if (w_mem_we) mem_q[ptr_q] <= w_shift_in;
      end
   end

   assign sda_oe     = oe_q;
   assign busy       = busy_q;
   assign xfer_valid = xv_q;
   assign xfer_rw    = xrw_q;
   assign xfer_data  = xdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench: an I2C master model drives the slave over a wired-AND SDA line.
module tb_i2c_slave_if;
   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_line;
   logic       sda_oe, busy, xfer_valid, xfer_rw;
   logic [7:0] xfer_data;
   logic [8:0] strobes [$];
   int         tests = 0;
   int         fails = 0;

   assign sda_line = m_sda & ~sda_oe;

   i2c_slave_if dut (
      .clk_i(clk), .rst_i(rst_n), .scl_i(m_scl), .sda_i(sda_line),
      .sda_oe(sda_oe), .busy(busy), .xfer_valid(xfer_valid),
      .xfer_rw(xfer_rw), .xfer_data(xfer_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (xfer_valid) strobes.push_back({xfer_rw, xfer_data});

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      m_sda = 1'b0; wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      m_sda = 1'b1; wait_clk(Q);
   endtask

   task automatic write_bit(input logic b);
      m_sda = b;    wait_clk(Q);
      m_scl = 1'b1; wait_clk(2*Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      b = sda_line; wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic nack);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      write_bit(nack);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
      wait_clk(5);
      tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests++; if (xfer_valid !== 1'b0) begin fails++; $display("FAIL reset_xfer_valid got=%b exp=0", xfer_valid); end
      tests++; if (xfer_rw !== 1'b0) begin fails++; $display("FAIL reset_xfer_rw got=%b exp=0", xfer_rw); end
      tests++; if (xfer_data !== 8'h00) begin fails++; $display("FAIL reset_xfer_data got=%h exp=00", xfer_data); end
      rst_n = 1'b1;
      wait_clk(5);
   endtask

   task automatic test_write();
      logic ack;
      strobes.delete();
      bus_start();
      send_byte(8'h44, ack);
      tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy got=%b exp=1", busy); end
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(i), ack);
         tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_data_ack[%0d] got=%b exp=0", i, ack); end
      end
      bus_stop();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
      tests++; if (strobes.size() != 4) begin fails++; $display("FAIL wr_strobe_count got=%0d exp=4", strobes.size()); end
      for (int i = 0; i < 4 && i < strobes.size(); i++) begin
         tests++; if (strobes[i] !== {1'b0, 8'(i)}) begin fails++; $display("FAIL wr_strobe[%0d] got=%h exp=%h", i, strobes[i], {1'b0, 8'(i)}); end
      end
   endtask

   task automatic test_read();
      logic       ack;
      logic [7:0] d;
      strobes.delete();
      bus_start();
      send_byte(8'h44, ack);
      tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rd_waddr_ack got=%b exp=0", ack); end
      bus_start();
      send_byte(8'h45, ack);
      tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rd_raddr_ack got=%b exp=0", ack); end
      for (int i = 0; i < 4; i++) begin
         recv_byte(d, i == 3);
         tests++; if (d !== 8'(i)) begin fails++; $display("FAIL rd_data[%0d] got=%h exp=%h", i, d, 8'(i)); end
      end
      tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rd_release_after_nack got=%b exp=0", sda_oe); end
      bus_stop();
      tests++; if (strobes.size() != 4) begin fails++; $display("FAIL rd_strobe_count got=%0d exp=4", strobes.size()); end
      for (int i = 0; i < 4 && i < strobes.size(); i++) begin
         tests++; if (strobes[i] !== {1'b1, 8'(i)}) begin fails++; $display("FAIL rd_strobe[%0d] got=%h exp=%h", i, strobes[i], {1'b1, 8'(i)}); end
      end
   endtask

   task automatic test_bad_addr();
      logic ack;
      strobes.delete();
      bus_start();
      send_byte(8'h46, ack);
      tests++; if (ack !== 1'b1) begin fails++; $display("FAIL bad_addr_ack got=%b exp=1", ack); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_addr_busy got=%b exp=0", busy); end
      send_byte(8'h55, ack);
      tests++; if (ack !== 1'b1) begin fails++; $display("FAIL bad_addr_data_ack got=%b exp=1", ack); end
      bus_stop();
      tests++; if (strobes.size() != 0) begin fails++; $display("FAIL bad_addr_strobes got=%0d exp=0", strobes.size()); end
   endtask

   task automatic test_wrap();
      logic       ack;
      logic [7:0] d, e;
      int         nacks = 0;
      bus_start();
      send_byte(8'h44, ack);
      if (ack) nacks++;
      for (int i = 0; i < 20; i++) begin
         send_byte(8'h40 + 8'(i), ack);
         if (ack) nacks++;
      end
      bus_stop();
      tests++; if (nacks != 0) begin fails++; $display("FAIL wrap_write_acks got=%0d nacks exp=0", nacks); end
      bus_start();
      send_byte(8'h45, ack);
      tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wrap_raddr_ack got=%b exp=0", ack); end
      for (int i = 0; i < 16; i++) begin
         e = (i < 4) ? 8'h50 + 8'(i) : 8'h40 + 8'(i);
         recv_byte(d, i == 15);
         tests++; if (d !== e) begin fails++; $display("FAIL wrap_rd[%0d] got=%h exp=%h", i, d, e); end
      end
      bus_stop();
   endtask

   task automatic test_abort();
      logic       ack;
      logic [7:0] d;
      bus_start();
      send_byte(8'h44, ack);
      strobes.delete();
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      bus_stop();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
      tests++; if (strobes.size() != 0) begin fails++; $display("FAIL abort_strobes got=%0d exp=0", strobes.size()); end
      bus_start();
      send_byte(8'h45, ack);
      recv_byte(d, 1'b1);
      bus_stop();
      tests++; if (d !== 8'h50) begin fails++; $display("FAIL abort_mem0 got=%h exp=50", d); end
   endtask

   task automatic test_reset_mid();
      logic       ack;
      logic [7:0] a = 8'h44;
      logic [7:0] d;
      int         n = 0;
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(a[i]);
      while (!sda_oe && n < 20) begin wait_clk(1); n++; end
      tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rstmid_ack_driven got=%b exp=1", sda_oe); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rstmid_async_release got=%b exp=0", sda_oe); end
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      rst_n = 1'b1; wait_clk(5);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      bus_start();
      send_byte(8'h45, ack);
      tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rstmid_raddr_ack got=%b exp=0", ack); end
      recv_byte(d, 1'b1);
      bus_stop();
      tests++; if (d !== 8'h00) begin fails++; $display("FAIL rstmid_mem0 got=%h exp=00", d); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_addr();
      test_wrap();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
